// File: rtl/program_loader.sv
// program_loader: boot-time loader that takes a framed byte stream
// (LEN_LO, LEN_HI, payload, XOR checksum) and writes the payload into
// instruction memory from byte address 0. The CPU is held in reset until the
// whole frame has been written and the checksum matches.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the current state and never on in_valid. When
// in_valid is low, or in a terminal state, the loader ignores in_data and
// holds all of its state.
module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_write_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] length;
    logic [7:0]  xor_sum;
    logic        accept;
    logic [15:0] frame_len;

    // The loader accepts bytes in every non-terminal state.
    always_comb begin
        in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                   (state == DATA)   || (state == CHECK);
    end

    assign accept    = in_valid && in_ready;
    assign frame_len = {in_data, len_lo};
    assign fsm_state = state;

    // Frame-parsing FSM; every output other than in_ready is registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= LEN_LO;
            len_lo           <= 8'd0;
            length           <= 16'd0;
            xor_sum          <= 8'd0;
            byte_count       <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= 8'd0;
            cpu_reset        <= 1'b1;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse per payload byte.
            mem_write_enable <= 1'b0;
            if (accept) begin
                case (state)
                    LEN_LO: begin
                        len_lo <= in_data;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        length     <= frame_len;
                        xor_sum    <= 8'd0;
                        byte_count <= '0;
                        // A frame of exactly 2^ADDR_WIDTH bytes is legal; only
                        // a larger one would need the address to wrap.
                        if (32'(frame_len) > (32'd1 << ADDR_WIDTH)) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else if (frame_len == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        mem_write_enable <= 1'b1;
                        mem_address      <= byte_count[ADDR_WIDTH-1:0];
                        mem_write_data   <= in_data;
                        xor_sum          <= xor_sum ^ in_data;
                        byte_count       <= byte_count + 1'b1;
                        if (32'(byte_count) + 32'd1 == 32'(length)) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (in_data == xor_sum) begin
                            state     <= RUN;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames into program_loader. Stimulus pushes
// each expected memory write onto a queue; a monitor pops and compares
// whenever the write strobe is seen. Status outputs are checked after each
// frame.
module tb_program_loader;

    localparam int AW = 10;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_write_data;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   byte_count;
    logic [2:0]    fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+7:0] exp_q[$];

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .cpu_reset        (cpu_reset),
        .load_done        (load_done),
        .load_error       (load_error),
        .byte_count       (byte_count),
        .fsm_state        (fsm_state)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && mem_write_enable) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         mem_address, mem_write_data);
            end else begin
                logic [AW+7:0] e;
                e = exp_q.pop_front();
                if ({mem_address, mem_write_data} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             mem_address, mem_write_data, e[AW+7:8], e[7:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic expect_write(input int addr, input logic [7:0] data);
        logic [AW-1:0] a;
        a = AW'(addr);
        exp_q.push_back({a, data});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 8) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0, expected 1 for byte 0x%0h", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
        end
    endtask

    task automatic gap3();
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic end_stream();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_we", mem_write_enable, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_write_data, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);
        check("rst_byte_count", byte_count, 0);
        reset = 1'b0;
    endtask

    task automatic status(input string tag, input logic cr, input logic dn,
                          input logic er, input int cnt);
        check({tag, "_cpu_reset"}, cpu_reset, 32'(cr));
        check({tag, "_done"}, load_done, 32'(dn));
        check({tag, "_error"}, load_error, 32'(er));
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_byte_count"}, byte_count, cnt);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clock);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic nominal_writes();
        expect_write(0, 8'h10);
        expect_write(1, 8'h03);
        expect_write(2, 8'h10);
        expect_write(3, 8'h00);
    endtask

    initial begin
        logic [7:0] nom[7];
        nom = '{8'h04, 8'h00, 8'h10, 8'h03, 8'h10, 8'h00, 8'h03};
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clock);
        do_reset();

        // Nominal back-to-back frame
        nominal_writes();
        foreach (nom[i]) send_byte(nom[i]);
        end_stream();
        status("nominal", 1'b0, 1'b1, 1'b0, 4);
        drain("nominal");

        // Checksum mismatch
        do_reset();
        nominal_writes();
        for (int i = 0; i < 6; i++) send_byte(nom[i]);
        send_byte(8'h04);
        end_stream();
        status("badsum", 1'b1, 1'b0, 1'b1, 4);
        drain("badsum");

        // Zero length, good and bad checksum
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end_stream();
        status("zero_ok", 1'b0, 1'b1, 1'b0, 0);
        drain("zero_ok");
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        end_stream();
        status("zero_bad", 1'b1, 1'b0, 1'b1, 0);
        drain("zero_bad");

        // Oversize length rejected in LEN_HI
        do_reset();
        send_byte(8'h01); send_byte(8'h04);
        end_stream();
        status("oversize", 1'b1, 1'b0, 1'b1, 0);
        drain("oversize");

        // Exactly full memory
        do_reset();
        for (int i = 0; i < 1024; i++) expect_write(i, 8'hAA);
        send_byte(8'h00); send_byte(8'h04);
        for (int i = 0; i < 1024; i++) send_byte(8'hAA);
        send_byte(8'h00);
        end_stream();
        status("full", 1'b0, 1'b1, 1'b0, 1024);
        drain("full");

        // Gaps of three idle cycles between bytes
        do_reset();
        nominal_writes();
        foreach (nom[i]) begin
            send_byte(nom[i]);
            if (i < 6) gap3();
        end
        end_stream();
        status("gaps", 1'b0, 1'b1, 1'b0, 4);
        drain("gaps");

        // Reset after two payload bytes, then a full frame
        do_reset();
        expect_write(0, 8'h10);
        expect_write(1, 8'h03);
        for (int i = 0; i < 4; i++) send_byte(nom[i]);
        end_stream();
        drain("partial");
        do_reset();
        nominal_writes();
        foreach (nom[i]) send_byte(nom[i]);
        end_stream();
        status("reload", 1'b0, 1'b1, 1'b0, 4);
        drain("reload");

        // Reset from RUN puts the CPU back in reset
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of `risc_v_cpu`. It receives a framed byte stream over a valid/ready interface and writes the payload, little-endian byte by byte, into the CPU instruction memory starting at byte address 0. It holds the CPU in reset until a complete frame with a correct checksum has been written, then releases it.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width of instruction memory. Capacity is 2^ADDR_WIDTH bytes.
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to `LEN_LO`.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_write_enable`  out  1  one-cycle write strobe to instruction memory.
- `mem_address`  out  ADDR_WIDTH  byte address of the write.
- `mem_write_data`  out  8  byte to write.
- `cpu_reset`  out  1  active-high reset to `risc_v_cpu`.
- `load_done`  out  1  frame loaded and verified; CPU running.
- `load_error`  out  1  frame rejected; CPU held in reset.
- `byte_count`  out  ADDR_WIDTH+1  payload bytes written so far.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit little-endian payload length L), then L payload bytes, then one checksum byte equal to the XOR of all payload bytes.
- Transfer: a byte is accepted on an edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- States: `LEN_LO`, `LEN_HI`, `DATA`, `CHECK`, `RUN`, `ERROR`.
- `LEN_LO`: on accept, latch the low byte and go to `LEN_HI`.
- `LEN_HI`: on accept, latch the high byte, clear the running XOR and `byte_count`, then:
  - L > 2^ADDR_WIDTH → `ERROR`.
  - L == 0 → `CHECK`.
  - otherwise → `DATA`.
- `DATA`: on accept:
  - issue a write of the byte to address `byte_count[ADDR_WIDTH-1:0]`;
  - XOR the byte into the running checksum;
  - increment `byte_count`;
  - when the accepted byte is the L-th byte, go to `CHECK`.
- `CHECK`: on accept, go to `RUN` if the byte equals the running XOR, else `ERROR`.
- `RUN`: terminal state. `cpu_reset`=0, `load_done`=1, `in_ready`=0.
- `ERROR`: terminal state. `cpu_reset`=1, `load_error`=1, `in_ready`=0.
- Only `reset` leaves `RUN` or `ERROR`.
- Boundary rules:
  - L == 2^ADDR_WIDTH is legal and fills memory exactly; the address never wraps.
  - `in_ready` is 1 in `LEN_LO`, `LEN_HI`, `DATA` and `CHECK`.
  - No writes are issued outside `DATA`.
- Reset mid-load: the partial frame is abandoned and the next byte is treated as LEN_LO. Already-written memory bytes are not cleared.

## Timing
- Reset values: `in_ready`=1, `mem_write_enable`=0, `mem_address`=0, `mem_write_data`=0, `cpu_reset`=1, `load_done`=0, `load_error`=0, `byte_count`=0, state `LEN_LO`.
- All outputs are registered except `in_ready`, which decodes the current state only and never depends on `in_valid`.
- Write latency:
  - A byte accepted at edge N produces `mem_write_enable`=1 with its address and data during cycle N→N+1.
  - The memory captures the write at edge N+1.
  - The strobe is exactly one cycle per accepted payload byte.
  - `byte_count` updates at edge N.
- Release latency:
  - The checksum byte accepted at edge N moves the state to `RUN` or `ERROR` at edge N.
  - `cpu_reset` falls (or `load_error` rises) at edge N. The last payload write has already completed at that point, because the checksum is accepted at least one cycle after the last payload byte.
- Throughput is one byte per cycle. Gaps in `in_valid` stall without side effects.

## Test plan
- Nominal, `ADDR_WIDTH`=10:
  - Stream 0x04,0x00,0x10,0x03,0x10,0x00,0x03 back-to-back.
  - Required: writes to addresses 0..3 of 0x10,0x03,0x10,0x00; `byte_count`=4; `cpu_reset`=0 and `load_done`=1 the cycle after the last byte is accepted.
- Checksum mismatch: same stream with last byte 0x04 → `load_error`=1, `cpu_reset` stays 1, `in_ready`=0, no write after address 3.
- Zero length: 0x00,0x00,0x00 → no writes, `load_done`=1. Repeat with 0x00,0x00,0x01 → `load_error`=1.
- Oversize: 0x01,0x04 → `ERROR` immediately, no writes. Stream 0x00,0x04, then 1024 bytes of 0xAA, then 0x00 → last write at address 1023, `byte_count`=1024, `load_done`=1.
- Backpressure/gaps: the nominal stream with `in_valid` low for 3 cycles between every byte → identical writes and result. No strobe during gaps.
- Reset mid-load:
  - Assert `reset` for one cycle after 2 payload bytes, then send the full nominal frame.
  - Required: outputs return to reset values, `byte_count`=0, then a normal load with `load_done`=1.
  - Also: `reset` in `RUN` reasserts `cpu_reset`=1.
